// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU issue path: ALU control codes, R-type opcode
// fields, the decoder aluOp encoding and the issue controller state encoding.
package alu_defs_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_MOV  = 4'b1101;
  localparam logic [3:0] ALU_BAD  = 4'b1111;

  localparam logic [10:0] RTYPE_ADD = 11'b10001011000;
  localparam logic [10:0] RTYPE_SUB = 11'b11001011000;
  localparam logic [10:0] RTYPE_AND = 11'b10001010000;
  localparam logic [10:0] RTYPE_ORR = 11'b10101010000;
  localparam logic [10:0] RTYPE_EOR = 11'b11001010000;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_MOV   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HOLD    = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_WAIT_WB = 2'b11
  } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_op_map.sv
// Combinational translation of decoder aluOp plus the R-type opcode field into
// the 4-bit ALU control code; flags R-type fields that have no mapping.
module alu_op_map
  import alu_defs_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode_field,
  output logic [3:0]  opcode,
  output logic        illegal
);

  always_comb begin
    opcode  = ALU_BAD;
    illegal = 1'b0;
    case (alu_op_e'(alu_op))
      ALUOP_MEM: opcode = ALU_ADD;
      ALUOP_CBZ: opcode = ALU_PASS;
      ALUOP_MOV: opcode = ALU_MOV;
      ALUOP_RTYPE: begin
        case (opcode_field)
          RTYPE_ADD: opcode = ALU_ADD;
          RTYPE_SUB: opcode = ALU_SUB;
          RTYPE_AND: opcode = ALU_AND;
          RTYPE_ORR: opcode = ALU_OR;
          RTYPE_EOR: opcode = ALU_XOR;
          default: begin
            opcode  = ALU_BAD;
            illegal = 1'b1;
          end
        endcase
      end
      default: opcode = ALU_BAD;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the ALU: accepts one instruction, holds the ALU
// inputs for a full sync window, captures the result and offers it to writeback.
module alu_issue_ctrl
  import alu_defs_pkg::*;
#(
  parameter int HOLD_CYCLES = 6,
  parameter int WIDTH       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issueValid,
  output logic             issueReady,
  input  logic [1:0]       aluOpIn,
  input  logic [10:0]      opcodeField,
  input  logic [WIDTH-1:0] regOne,
  input  logic [WIDTH-1:0] regTwo,
  input  logic [WIDTH-1:0] immediate,
  input  logic             aluSrc,
  input  logic             invertIn,
  output logic [WIDTH-1:0] inOne,
  output logic [WIDTH-1:0] inTwo,
  output logic [3:0]       opcode,
  output logic             invertZeroFlag,
  input  logic [WIDTH-1:0] aluResult,
  input  logic             aluZero,
  input  logic             aluCarry,
  output logic             wbValid,
  input  logic             wbReady,
  output logic [WIDTH-1:0] wbResult,
  output logic             wbZero,
  output logic             wbCarry,
  output logic             illegalOp
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] COUNT_LAST = CW'(HOLD_CYCLES - 1);

  issue_state_e     state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] in_one_q, in_one_d;
  logic [WIDTH-1:0] in_two_q, in_two_d;
  logic [3:0]       opcode_q, opcode_d;
  logic             invert_q, invert_d;
  logic             wb_valid_q, wb_valid_d;
  logic [WIDTH-1:0] wb_result_q, wb_result_d;
  logic             wb_zero_q, wb_zero_d;
  logic             wb_carry_q, wb_carry_d;

  logic [3:0] map_opcode;
  logic       map_illegal;
  logic       issue_ready;
  logic       accept;

  alu_op_map u_op_map (
    .alu_op       (aluOpIn),
    .opcode_field (opcodeField),
    .opcode       (map_opcode),
    .illegal      (map_illegal)
  );

  assign issue_ready = (state_q == ST_IDLE) || ((state_q == ST_WAIT_WB) && wbReady);
  assign accept      = issueValid && issue_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    in_one_d    = in_one_q;
    in_two_d    = in_two_q;
    opcode_d    = opcode_q;
    invert_d    = invert_q;
    wb_valid_d  = wb_valid_q;
    wb_result_d = wb_result_q;
    wb_zero_d   = wb_zero_q;
    wb_carry_d  = wb_carry_q;

    case (state_q)
      ST_HOLD: begin
        count_d = count_q + 1'b1;
        if (count_q == COUNT_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        wb_result_d = aluResult;
        wb_zero_d   = aluZero;
        wb_carry_d  = aluCarry;
        wb_valid_d  = 1'b1;
        state_d     = ST_WAIT_WB;
      end
      ST_WAIT_WB: begin
        if (wbReady) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: ;
    endcase

    // accept is only possible from IDLE or a draining WAIT_WB, so it overrides
    // the per-state next state to give back-to-back issue.
    if (accept) begin
      in_one_d = regOne;
      in_two_d = aluSrc ? immediate : regTwo;
      opcode_d = map_opcode;
      invert_d = invertIn;
      count_d  = '0;
      state_d  = ST_HOLD;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      in_one_q    <= '0;
      in_two_q    <= '0;
      opcode_q    <= '0;
      invert_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_zero_q   <= 1'b0;
      wb_carry_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_one_q    <= in_one_d;
      in_two_q    <= in_two_d;
      opcode_q    <= opcode_d;
      invert_q    <= invert_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_zero_q   <= wb_zero_d;
      wb_carry_q  <= wb_carry_d;
    end
  end

  assign issueReady     = issue_ready;
  assign inOne          = in_one_q;
  assign inTwo          = in_two_q;
  assign opcode         = opcode_q;
  assign invertZeroFlag = invert_q;
  assign wbValid        = wb_valid_q;
  assign wbResult       = wb_result_q;
  assign wbZero         = wb_zero_q;
  assign wbCarry        = wb_carry_q;
  assign illegalOp      = accept && map_illegal;

endmodule
